// File: rtl/corevx_ptw.sv
// Sv32 page table walker. It resolves a TLB miss from the cache by reading
// one or two PTEs over an Avalon-MM read master. The result is a PPN plus
// the leaf access bits, or a page fault, or an access fault.
module corevx_ptw (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        resolve_request,
    input  logic [19:0] resolve_virtual_address,
    input  logic [21:0] satp_ppn,
    output logic        resolve_done,
    output logic        resolve_pagefault,
    output logic        resolve_accessfault,
    output logic [7:0]  resolve_access_bits,
    output logic [21:0] resolve_physical_address,
    output logic [33:0] avl_address,
    output logic        avl_read,
    input  logic        avl_waitrequest,
    input  logic [31:0] avl_readdata,
    input  logic        avl_readdatavalid,
    input  logic [1:0]  avl_response
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // A PTE is invalid if V is clear or if it is writable without being readable.
    function automatic logic pte_invalid(input logic [7:0] flags);
        pte_invalid = (flags[0] == 1'b0) || ((flags[1] == 1'b0) && (flags[2] == 1'b1));
    endfunction

    // A PTE is a leaf when it grants read or execute permission.
    function automatic logic pte_leaf(input logic [7:0] flags);
        pte_leaf = (flags[1] == 1'b1) || (flags[3] == 1'b1);
    endfunction

    state_t      state_q, state_d;
    logic        lvl_q, lvl_d;
    logic [19:0] vpn_q, vpn_d;
    logic [33:0] addr_q, addr_d;
    logic        read_q, read_d;
    logic        done_q, done_d;
    logic        pf_q, pf_d;
    logic        af_q, af_d;
    logic [7:0]  bits_q, bits_d;
    logic [21:0] ppn_q, ppn_d;

    // Result of evaluating the returned PTE. It is only committed when the walk terminates.
    logic        finish_s;
    logic        res_pf_s;
    logic        res_af_s;
    logic [7:0]  res_bits_s;
    logic [21:0] res_ppn_s;

    // Next-state logic and PTE evaluation for the walk FSM.
    always_comb begin
        state_d    = state_q;
        lvl_d      = lvl_q;
        vpn_d      = vpn_q;
        addr_d     = addr_q;
        read_d     = read_q;
        done_d     = 1'b0;
        pf_d       = pf_q;
        af_d       = af_q;
        bits_d     = bits_q;
        ppn_d      = ppn_q;
        finish_s   = 1'b0;
        res_pf_s   = 1'b0;
        res_af_s   = 1'b0;
        res_bits_s = 8'h00;
        res_ppn_s  = 22'd0;

        case (state_q)
            S_IDLE: begin
                if (resolve_request) begin
                    vpn_d   = resolve_virtual_address;
                    addr_d  = {satp_ppn, resolve_virtual_address[19:10], 2'b00};
                    lvl_d   = 1'b1;
                    read_d  = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    read_d  = 1'b0;
                end
            end
            S_ISSUE: begin
                if (!avl_waitrequest) begin
                    read_d  = 1'b0;
                    state_d = S_WAIT;
                end else begin
                    read_d  = 1'b1;
                end
            end
            S_WAIT: begin
                if (avl_readdatavalid) begin
                    if (avl_response != 2'b00) begin
                        finish_s = 1'b1;
                        res_af_s = 1'b1;
                    end else if (pte_invalid(avl_readdata[7:0])) begin
                        finish_s = 1'b1;
                        res_pf_s = 1'b1;
                    end else if (pte_leaf(avl_readdata[7:0])) begin
                        finish_s = 1'b1;
                        if (lvl_q) begin
                            // A megapage leaf must have its low PPN field clear.
                            if (avl_readdata[19:10] != 10'd0) begin
                                res_pf_s = 1'b1;
                            end else begin
                                res_ppn_s  = {avl_readdata[31:20], vpn_q[9:0]};
                                res_bits_s = avl_readdata[7:0];
                            end
                        end else begin
                            res_ppn_s  = avl_readdata[31:10];
                            res_bits_s = avl_readdata[7:0];
                        end
                    end else if (lvl_q) begin
                        // Pointer to the next-level table: descend one level.
                        addr_d  = {avl_readdata[31:10], vpn_q[9:0], 2'b00};
                        lvl_d   = 1'b0;
                        read_d  = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        finish_s = 1'b1;
                        res_pf_s = 1'b1;
                    end
                end else begin
                    state_d = S_WAIT;
                end

                if (finish_s) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pf_d    = res_pf_s;
                    af_d    = res_af_s;
                    bits_d  = res_bits_s;
                    ppn_d   = res_ppn_s;
                end else begin
                    done_d  = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                lvl_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                read_d  = 1'b0;
                lvl_d   = 1'b1;
            end
        endcase
    end

    // State and registered-output flops; reset abandons any walk in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lvl_q   <= 1'b1;
            vpn_q   <= 20'd0;
            addr_q  <= 34'd0;
            read_q  <= 1'b0;
            done_q  <= 1'b0;
            pf_q    <= 1'b0;
            af_q    <= 1'b0;
            bits_q  <= 8'h00;
            ppn_q   <= 22'd0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            vpn_q   <= vpn_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            done_q  <= done_d;
            pf_q    <= pf_d;
            af_q    <= af_d;
            bits_q  <= bits_d;
            ppn_q   <= ppn_d;
        end
    end

    assign resolve_done             = done_q;
    assign resolve_pagefault        = pf_q;
    assign resolve_accessfault      = af_q;
    assign resolve_access_bits      = bits_q;
    assign resolve_physical_address = ppn_q;
    assign avl_address              = addr_q;
    assign avl_read                 = read_q;

endmodule
